dm_waitstate: RTL and testbench
===============================

# dm_waitstate

Parametrised data memory for the MIPS pipeline's MEM stage, replacing the single-cycle memory with a handshaked, multi-cycle block. It models configurable wait states, supports byte/half/word loads and stores with sign/zero extension, and flags misaligned or out-of-range accesses instead of silently corrupting data. After reset it clears its storage by sweeping every word, and reports Busy so the hazard unit stalls the pipeline.

## Interface
- DEPTH_LOG2, 10: memory holds 2^DEPTH_LOG2 32-bit words.
- WAIT_CYCLES, 2: extra cycles between request acceptance and response (0 allowed, max 15).
- Clk  in  1  clock, all state changes on rising edge.
- Reset  in  1  synchronous, active-high.
- Req  in  1  access request; sampled only in IDLE.
- WE  in  1  1 = store, 0 = load; sampled with Req.
- Size  in  2  00 byte, 01 half, 10 word; 11 treated as fault.
- SignExt  in  1  1 = sign-extend loads, 0 = zero-extend.
- Addr  in  32  byte address.
- WD  in  32  store data; low byte/half used for sub-word stores.
- RD  out  32  load result, valid while Ack = 1.
- Ack  out  1  one-cycle response pulse.
- Fault  out  1  valid with Ack; access was misaligned, out of range or bad Size.
- Busy  out  1  high whenever the block is not in IDLE.

## Operation
- States: INIT, IDLE, WAIT, RESP.
- INIT: clear counter sweeps word index 0..2^DEPTH_LOG2-1, writes 0 per cycle, then goes to IDLE. Duration is exactly 2^DEPTH_LOG2 cycles. Req is ignored.
- IDLE: on Req=1, capture WE, Size, SignExt, Addr, WD.
  - If faulty, go to RESP with Fault=1.
  - Else if WAIT_CYCLES=0, perform the access on this edge and go to RESP.
  - Else load the wait counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT: decrement the counter each cycle. On the edge where the counter is 0, perform the access and go to RESP.
- RESP: Ack=1 for one cycle, then IDLE. Req in RESP is ignored; it must be held to be accepted in IDLE.
- Fault conditions:
  - Size=11.
  - Half with Addr[0]=1.
  - Word with Addr[1:0]≠0.
  - Addr[31:DEPTH_LOG2+2]≠0.
- On fault: no memory write, RD=0.
- Stores (little-endian lanes):
  - Word: replaces the whole word.
  - Half: writes lane Addr[1] (bits 15:0 or 31:16).
  - Byte: writes lane Addr[1:0].
  - Other lanes are preserved (read-modify-write of the captured word).
- Loads extract the same lanes and extend per SignExt. RD is registered at access time and held until the next access completes. RD for stores is 0.

## Timing
- Reset values: state INIT, Ack=0, Fault=0, RD=0, Busy=1.
- Reset in any state, including mid-WAIT, abandons the pending access (no write) and restarts INIT.
- Request latency: Req accepted at edge t gives Ack high in the cycle after edge t+WAIT_CYCLES. Faults respond after edge t regardless of WAIT_CYCLES.
- Throughput: one access per WAIT_CYCLES+2 cycles (IDLE cycle plus WAIT plus RESP).
- Busy is registered: high from the edge after acceptance through RESP inclusive. Busy is low only in IDLE.
- Memory array is written only at the INIT sweep or the access edge, never at other times.

## Structure
- Shared package dm_pkg holds:
  - Size encodings (DMSIZE_BYTE/HALF/WORD).
  - State enum (ST_INIT, ST_IDLE, ST_WAIT, ST_RESP).
  - Fault-check helper constants.
- One sub-module, dm_lane_merge: combinational lane extract/extend for loads and lane merge for stores. Its inputs are the original word, Addr[1:0], Size, SignExt and WD.
- Top holds the FSM, wait counter, clear counter and memory array.

## Test plan
- Reset with DEPTH_LOG2=4: Busy=1 for exactly 16 cycles after Reset falls. Then a word load at 0x3C returns 0 with Fault=0.
- WAIT_CYCLES=2, store word 0xDEADBEEF at 0x10, then load word: Ack appears 3 cycles after each acceptance edge, and RD=0xDEADBEEF.
- Store byte 0x7F at 0x11 over 0xDEADBEEF, then:
  - Load word at 0x10: RD=0xDEAD7FEF.
  - Load half at 0x12 with SignExt=1: RD=0xFFFFDEAD.
  - Load byte at 0x13 with SignExt=0: RD=0x000000DE.
- Misaligned word load at 0x12: Ack with Fault=1 after 1 cycle, RD=0. An out-of-range store at 0x40 (DEPTH_LOG2=4): Fault=1 and memory unchanged.
- Store accepted, then Reset asserted during WAIT: no Ack, INIT reruns, and the target word reads 0 afterwards.
- WAIT_CYCLES=0 with back-to-back Req held high: Acks every 2nd cycle, and Req during RESP is not double-accepted.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the wait-stated MEM-stage data memory.
package dm_pkg;

    typedef enum logic [1:0] {
        DMSIZE_BYTE = 2'b00,
        DMSIZE_HALF = 2'b01,
        DMSIZE_WORD = 2'b10,
        DMSIZE_BAD  = 2'b11
    } dm_size_e;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } dm_state_e;

    // Address bits that must be zero for an aligned half / word access.
    localparam logic [1:0] HALF_ALIGN_MASK = 2'b01;
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;
    localparam int unsigned WORD_OFFSET_BITS = 2;

endpackage

// File: rtl/dm_lane_merge.sv
// Little-endian lane extraction/extension for loads and lane merge for stores.
module dm_lane_merge
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wd,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    always_comb begin
        lane8      = word[{addr_lo, 3'b000} +: 8];
        lane16     = word[{addr_lo[1], 4'b0000} +: 16];
        load_data  = '0;
        store_word = word;
        case (size)
            DMSIZE_BYTE: begin
                load_data = {{24{sign_ext & lane8[7]}}, lane8};
                store_word[{addr_lo, 3'b000} +: 8] = wd[7:0];
            end
            DMSIZE_HALF: begin
                load_data = {{16{sign_ext & lane16[15]}}, lane16};
                store_word[{addr_lo[1], 4'b0000} +: 16] = wd[15:0];
            end
            DMSIZE_WORD: begin
                load_data  = word;
                store_word = wd;
            end
            default: begin
                load_data  = '0;
                store_word = word;
            end
        endcase
    end

endmodule

// File: rtl/dm_waitstate.sv
// Handshaked multi-cycle data memory: clear sweep after reset, configurable wait
// states, sub-word access with extension, and fault reporting.
module dm_waitstate
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        WE,
    input  logic [1:0]  Size,
    input  logic        SignExt,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        Ack,
    output logic        Fault,
    output logic        Busy
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam int unsigned ABITS  = DEPTH_LOG2 + WORD_OFFSET_BITS;

    logic [31:0]           mem [DEPTH];
    dm_state_e             state;
    logic [DEPTH_LOG2-1:0] clr_cnt;
    logic [3:0]            wait_cnt;

    logic                  cap_we;
    logic [1:0]            cap_size;
    logic                  cap_sext;
    logic [ABITS-1:0]      cap_addr;
    logic [31:0]           cap_wd;

    logic                  in_idle;
    logic                  acc_we;
    logic [1:0]            acc_size;
    logic                  acc_sext;
    logic [ABITS-1:0]      acc_addr;
    logic [31:0]           acc_wd;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [31:0]           old_word;
    logic [31:0]           load_data;
    logic [31:0]           store_word;
    logic                  req_fault;
    logic                  do_access;

    // With zero wait states the access happens on the accept edge, so use live inputs.
    assign in_idle  = (state == ST_IDLE);
    assign acc_we   = in_idle ? WE      : cap_we;
    assign acc_size = in_idle ? Size    : cap_size;
    assign acc_sext = in_idle ? SignExt : cap_sext;
    assign acc_addr = in_idle ? Addr[ABITS-1:0] : cap_addr;
    assign acc_wd   = in_idle ? WD      : cap_wd;
    assign word_idx = acc_addr[ABITS-1:WORD_OFFSET_BITS];
    assign old_word = mem[word_idx];

    assign req_fault = (Size == DMSIZE_BAD)
                    || ((Size == DMSIZE_HALF) && |(Addr[1:0] & HALF_ALIGN_MASK))
                    || ((Size == DMSIZE_WORD) && |(Addr[1:0] & WORD_ALIGN_MASK))
                    || ((Addr >> ABITS) != '0);

    assign do_access = !Reset
                    && ((in_idle && Req && !req_fault && (WAIT_CYCLES == 0))
                     || ((state == ST_WAIT) && (wait_cnt == '0)));

    dm_lane_merge u_lane_merge (
        .word       (old_word),
        .addr_lo    (acc_addr[1:0]),
        .size       (acc_size),
        .sign_ext   (acc_sext),
        .wd         (acc_wd),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (state == ST_INIT) begin
                mem[clr_cnt] <= '0;
            end else if (do_access && acc_we) begin
                mem[word_idx] <= store_word;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_INIT;
            clr_cnt  <= '0;
            wait_cnt <= '0;
            cap_we   <= 1'b0;
            cap_size <= '0;
            cap_sext <= 1'b0;
            cap_addr <= '0;
            cap_wd   <= '0;
            RD       <= '0;
            Ack      <= 1'b0;
            Fault    <= 1'b0;
            Busy     <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (&clr_cnt) begin
                        state <= ST_IDLE;
                        Busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (Req) begin
                        cap_we   <= WE;
                        cap_size <= Size;
                        cap_sext <= SignExt;
                        cap_addr <= Addr[ABITS-1:0];
                        cap_wd   <= WD;
                        Busy     <= 1'b1;
                        if (req_fault) begin
                            state <= ST_RESP;
                            Ack   <= 1'b1;
                            Fault <= 1'b1;
                            RD    <= '0;
                        end else if (WAIT_CYCLES == 0) begin
                            state <= ST_RESP;
                            Ack   <= 1'b1;
                            Fault <= 1'b0;
                            RD    <= WE ? '0 : load_data;
                        end else begin
                            wait_cnt <= 4'(WAIT_CYCLES - 1);
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_RESP;
                        Ack   <= 1'b1;
                        Fault <= 1'b0;
                        RD    <= cap_we ? '0 : load_data;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    Ack   <= 1'b0;
                    Fault <= 1'b0;
                    Busy  <= 1'b0;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_waitstate.sv
// Scoreboard bench: a 2-wait-state instance for the functional vectors and a
// zero-wait-state instance for back-to-back acceptance.
module tb_dm_waitstate;
    import dm_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;

    logic        req0 = 0, we0 = 0, sext0 = 0;
    logic [1:0]  size0 = 0;
    logic [31:0] addr0 = 0, wd0 = 0;
    logic [31:0] rd0;
    logic        ack0, fault0, busy0;

    logic        req1 = 0, we1 = 0, sext1 = 0;
    logic [1:0]  size1 = 0;
    logic [31:0] addr1 = 0, wd1 = 0;
    logic [31:0] rd1;
    logic        ack1, fault1, busy1;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        fault;
        int          accept;
        int          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    int   base;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    dm_waitstate #(.DEPTH_LOG2(4), .WAIT_CYCLES(2)) dut0 (
        .Clk(Clk), .Reset(Reset), .Req(req0), .WE(we0), .Size(size0), .SignExt(sext0),
        .Addr(addr0), .WD(wd0), .RD(rd0), .Ack(ack0), .Fault(fault0), .Busy(busy0)
    );

    dm_waitstate #(.DEPTH_LOG2(4), .WAIT_CYCLES(0)) dut1 (
        .Clk(Clk), .Reset(Reset), .Req(req1), .WE(we1), .Size(size1), .SignExt(sext1),
        .Addr(addr1), .WD(wd1), .RD(rd1), .Ack(ack1), .Fault(fault1), .Busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge Clk) begin
        if (!Reset && ack0) begin
            if (q0.size() == 0) begin
                chk("dut0 unexpected ack", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                chk({e0.name, " rd"}, rd0, e0.rd);
                chk({e0.name, " fault"}, 32'(fault0), 32'(e0.fault));
                chk({e0.name, " latency"}, 32'(cyc - e0.accept), 32'(e0.lat));
            end
        end
    end

    always @(negedge Clk) begin
        if (!Reset && ack1) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected ack", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk({e1.name, " rd"}, rd1, e1.rd);
                chk({e1.name, " fault"}, 32'(fault1), 32'(e1.fault));
                chk({e1.name, " latency"}, 32'(cyc - e1.accept), 32'(e1.lat));
            end
        end
    end

    task automatic wait_idle0(input string name);
        int n = 0;
        while (busy0 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (busy0) chk({name, " idle timeout"}, 32'd1, 32'd0);
    endtask

    task automatic issue0(input string name, input logic we, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_f);
        exp_t e;
        wait_idle0(name);
        we0 = we; size0 = sz; sext0 = sx; addr0 = a; wd0 = d; req0 = 1'b1;
        e.name = name; e.rd = exp_rd; e.fault = exp_f;
        e.accept = cyc + 1; e.lat = exp_f ? 0 : 2;
        q0.push_back(e);
        @(negedge Clk);
        req0 = 1'b0;
        chk({name, " busy after accept"}, 32'(busy0), 32'd1);
    endtask

    task automatic count_busy(input string name);
        int n0 = 0;
        int n1 = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy0 && !busy1) break;
            if (busy0) n0++;
            if (busy1) n1++;
            @(negedge Clk);
        end
        chk({name, " dut0 busy cycles"}, 32'(n0), 32'd16);
        chk({name, " dut1 busy cycles"}, 32'(n1), 32'd16);
    endtask

    initial begin
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        chk("reset rd", rd0, 32'h0);
        chk("reset ack", 32'(ack0), 32'd0);
        chk("reset fault", 32'(fault0), 32'd0);
        chk("reset busy", 32'(busy0), 32'd1);
        chk("reset dut1 busy", 32'(busy1), 32'd1);
        Reset = 1'b0;
        count_busy("init");

        issue0("ld w 3c",      0, DMSIZE_WORD, 0, 32'h3C, 32'h0,        32'h0,        0);
        issue0("st w 10",      1, DMSIZE_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0);
        issue0("ld w 10",      0, DMSIZE_WORD, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0);
        issue0("st b 11",      1, DMSIZE_BYTE, 0, 32'h11, 32'h1234567F, 32'h0,        0);
        issue0("ld w 10 b",    0, DMSIZE_WORD, 0, 32'h10, 32'h0,        32'hDEAD7FEF, 0);
        issue0("ld h 12 sx",   0, DMSIZE_HALF, 1, 32'h12, 32'h0,        32'hFFFFDEAD, 0);
        issue0("ld b 13 zx",   0, DMSIZE_BYTE, 0, 32'h13, 32'h0,        32'h000000DE, 0);
        issue0("ld w 12 mis",  0, DMSIZE_WORD, 0, 32'h12, 32'h0,        32'h0,        1);
        issue0("st w 40 oor",  1, DMSIZE_WORD, 0, 32'h40, 32'h11111111, 32'h0,        1);
        issue0("ld w 00",      0, DMSIZE_WORD, 0, 32'h00, 32'h0,        32'h0,        0);
        issue0("st h 16",      1, DMSIZE_HALF, 0, 32'h16, 32'hAAAA8001, 32'h0,        0);
        issue0("ld h 16 sx",   0, DMSIZE_HALF, 1, 32'h16, 32'h0,        32'hFFFF8001, 0);
        issue0("ld w 14",      0, DMSIZE_WORD, 0, 32'h14, 32'h0,        32'h80010000, 0);
        issue0("ld b 17 sx",   0, DMSIZE_BYTE, 1, 32'h17, 32'h0,        32'hFFFFFF80, 0);
        issue0("ld sz11",      0, DMSIZE_BAD,  0, 32'h20, 32'h0,        32'h0,        1);
        issue0("ld b 11 sx",   0, DMSIZE_BYTE, 1, 32'h11, 32'h0,        32'h0000007F, 0);
        issue0("ld h 13 mis",  0, DMSIZE_HALF, 0, 32'h13, 32'h0,        32'h0,        1);

        // Store accepted, then reset lands while it is still waiting.
        wait_idle0("rst mid wait");
        we0 = 1; size0 = DMSIZE_WORD; addr0 = 32'h24; wd0 = 32'h55AA55AA; req0 = 1'b1;
        @(negedge Clk);
        req0 = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        count_busy("reinit");
        issue0("ld w 24 after rst", 0, DMSIZE_WORD, 0, 32'h24, 32'h0, 32'h0, 0);
        wait_idle0("drain dut0");

        // Zero wait states: Req held high is accepted every other cycle.
        we1 = 1; size1 = DMSIZE_WORD; sext1 = 0; addr1 = 32'h08; wd1 = 32'h01020304;
        req1 = 1'b1;
        base = cyc;
        for (int k = 0; k < 3; k++) begin
            e1.name = $sformatf("b2b st %0d", k); e1.rd = 32'h0; e1.fault = 0;
            e1.accept = base + 1 + 2 * k; e1.lat = 0;
            q1.push_back(e1);
        end
        repeat (6) @(negedge Clk);
        we1 = 0;
        base = cyc;
        for (int k = 0; k < 2; k++) begin
            e1.name = $sformatf("b2b ld %0d", k); e1.rd = 32'h01020304; e1.fault = 0;
            e1.accept = base + 1 + 2 * k; e1.lat = 0;
            q1.push_back(e1);
        end
        repeat (4) @(negedge Clk);
        req1 = 1'b0;

        for (int i = 0; i < 20 && (q0.size() + q1.size()) != 0; i++) @(negedge Clk);
        repeat (3) @(negedge Clk);
        chk("scoreboard drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
